// File: rtl/bcd_scan_if.sv
// bcd_scan_if: control inputs and multiplexed display outputs of bcd_scan_ctrl.
//   inc       - count-increment request, sampled every rising edge
//   clear     - synchronous count clear, has priority over inc
//   hold      - freezes the displayed snapshot while counting continues
//   digit_val - BCD value of the digit currently being scanned
//   digit_sel - active-low one-hot select of the scanned digit
//   blank     - scanned digit is a suppressed leading zero
//   overflow  - one-cycle pulse after an all-9s rollover
// The master modport drives the controls; the slave modport is the controller.
interface bcd_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  inc;
    logic                  clear;
    logic                  hold;
    logic [3:0]            digit_val;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  blank;
    logic                  overflow;

    modport master (
        output inc, clear, hold,
        input  digit_val, digit_sel, blank, overflow
    );

    modport slave (
        input  inc, clear, hold,
        output digit_val, digit_sel, blank, overflow
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: NUM_DIGITS-digit BCD event counter with a time-multiplexed
// display scanner and optional leading-zero blanking.
//   clk   - rising-edge clock
//   n_rst - asynchronous active-low reset
//   bus   - bcd_scan_if slave: inc/clear/hold in, digit_val/digit_sel/blank/overflow out
// The counter increments in a single cycle with ripple carry. A snapshot of
// the count feeds the display and can be frozen with hold. The scanner
// selects each digit for SCAN_DIV cycles, independent of the count controls.
module bcd_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_LZ   = 1
) (
    input logic       clk,
    input logic       n_rst,
    bcd_scan_if.slave bus
);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [3:0]       cnt     [NUM_DIGITS];
    logic [3:0]       cnt_nxt [NUM_DIGITS];
    logic [3:0]       snap    [NUM_DIGITS];
    logic             carry;
    logic             overflow_nxt;
    logic             overflow_q;
    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    logic             upper_zero;

    // Ripple carry: carry enters digit 0 on an increment and keeps moving up
    // only through digits at 9. A carry out of the top digit is the rollover.
    always_comb begin
        carry = bus.inc & ~bus.clear;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.clear) begin
                cnt_nxt[i] = 4'd0;
            end else if (carry) begin
                cnt_nxt[i] = (cnt[i] == 4'd9) ? 4'd0 : cnt[i] + 4'd1;
            end else begin
                cnt_nxt[i] = cnt[i];
            end
            carry = carry & (cnt[i] == 4'd9);
        end
        overflow_nxt = carry;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cnt[i]  <= 4'd0;
                snap[i] <= 4'd0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cnt[i] <= cnt_nxt[i];
                // The snapshot takes the post-edge count so the display never
                // lags the counter by a cycle when hold is low.
                if (!bus.hold) begin
                    snap[i] <= cnt_nxt[i];
                end
            end
            overflow_q <= overflow_nxt;
        end
    end

    // Scan timing: prescaler wrap advances the digit index.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // A digit is a leading zero when it and every more significant digit are
    // zero; digit 0 is always shown so a zero count still displays "0".
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx) && snap[j] != 4'd0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign bus.blank     = (BLANK_LZ != 0) && (idx != '0) && upper_zero;
    assign bus.digit_sel = ~(NUM_DIGITS'(1) << idx);
    assign bus.digit_val = snap[idx];
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/bcd_scan_ctrl.md
BCD_SCAN_CTRL -- requirements
Module: bcd_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits counted and scanned; legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 1000: clock cycles each digit is selected; legal range 2..65535.
REQ-003 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 inc  input  1  count-increment request, sampled every rising edge.
REQ-008 clear  input  1  synchronous count clear.
REQ-009 hold  input  1  1 freezes the displayed snapshot; counting continues.
REQ-010 digit_val  output  4  BCD value of the currently scanned digit, driven to the shared 7-segment decoder.
REQ-011 digit_sel  output  NUM_DIGITS  active-low one-hot select for the scanned digit.
REQ-012 blank  output  1  1 means the scanned digit is a suppressed leading zero.
REQ-013 overflow  output  1  one-cycle pulse on all-9s rollover.

Function
REQ-014 SHALL hold NUM_DIGITS 4-bit count registers cnt[i], with cnt[0] least significant; every cnt[i] stays within 0..9 at all times.
REQ-015 SHALL, on an edge with clear=1, set all cnt[i]=0 and ignore inc; clear has priority.
REQ-016 SHALL, on an edge with inc=1 and clear=0, add 1 to cnt[0] with ripple carry: a digit at 9 receiving a carry becomes 0 and carries into the next digit; the increment completes in a single cycle.
REQ-017 SHALL, when every digit is 9 and an increment occurs, wrap all digits to 0 and assert overflow for exactly the next cycle; otherwise overflow=0.
REQ-018 SHALL keep a snapshot register snap[i]: loaded with the next-state value of cnt[i] on every edge with hold=0; unchanged while hold=1.
REQ-019 SHALL contain a prescaler counting 0..SCAN_DIV-1 that wraps to 0 after SCAN_DIV-1.
REQ-020 SHALL advance scan index idx (0..NUM_DIGITS-1) by 1 on each prescaler wrap, wrapping from NUM_DIGITS-1 to 0; each digit is therefore selected for exactly SCAN_DIV cycles.
REQ-021 SHALL make digit_sel, digit_val and blank combinational functions of the registered idx and snap only: digit_sel[idx]=0 with all other bits 1, and digit_val=snap[idx].
REQ-022 SHALL drive blank=1 only when BLANK_LZ=1, idx!=0, and snap[j]=0 for every j>=idx; otherwise blank=0.
REQ-023 SHALL leave scanning unaffected by inc, clear and hold.
REQ-024 SHALL give the prescaler and idx the minimum width holding SCAN_DIV-1 and NUM_DIGITS-1 respectively.
REQ-025 SHALL treat NUM_DIGITS=1 as idx constant 0 with digit_sel always 0.

Reset
REQ-026 SHALL, on n_rst low, immediately and asynchronously clear cnt, snap, prescaler, idx and overflow, independent of clk.
REQ-027 SHALL present, during and after reset: digit_sel = all ones except bit 0 = 0, digit_val=0, blank=0, overflow=0.
REQ-028 SHALL resume normal counting and scanning on the first rising edge after n_rst deasserts; reset mid-scan or mid-count discards all state.

Verification
REQ-029 Reset: assert n_rst=0 mid-operation with no clock edge -> digit_sel=4'b1110, digit_val=0, overflow=0 immediately.
REQ-030 Carry: 10 inc pulses from 0000 -> cnt=0010; scanning idx=1 gives digit_val=1.
REQ-031 Rollover: preload 9999 by counting, then one inc -> cnt=0000; overflow=1 for exactly one cycle.
REQ-032 Scan, SCAN_DIV=4: digit_sel follows 1110, 1101, 1011, 0111, 1110, with each value held exactly 4 cycles.
REQ-033 Hold and blank: count to 0042, set hold=1, apply 5 incs -> display stays 0042 with blank=1 on idx 2 and 3; release hold -> next display 0047.
REQ-034 Priority: inc=1 and clear=1 on the same edge with cnt=0123 -> cnt=0000, overflow=0.
